// File: rtl/keypad_scan_pkg.sv
// Shared keypad matrix dimensions and the (column, row) -> key code mapping.
package keypad_scan_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int KEY_W    = 4;
  localparam int SNAP_W   = NUM_COLS * NUM_ROWS;

  typedef logic [KEY_W-1:0] key_code_t;

  function automatic key_code_t key_code(input logic [1:0] col_idx, input logic [1:0] row_idx);
    return KEY_W'(int'(col_idx) * NUM_ROWS + int'(row_idx));
  endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchronizer for the active-low keypad rows; resets to the idle (all-high) level.
module keypad_scan_sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column strobing, whole-scan debounce and single/multi key classification.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int CLK_DIV  = 10000,
  parameter int DEBOUNCE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [KEY_W-1:0]    key,
  output logic                key_valid,
  output logic                key_down,
  output logic                multi
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic [NUM_ROWS-1:0] row_sync;
  logic [NUM_ROWS-1:0] row_pressed;
  logic [DIV_W-1:0]    div;
  logic [1:0]          col_idx;
  logic [1:0]          idx_next;
  logic [SNAP_W-1:0]   snap;
  logic [SNAP_W-1:0]   prev_snap;
  logic [SNAP_W-1:0]   deb;
  logic [CNT_W-1:0]    stable_cnt;

  logic [SNAP_W-1:0]   snap_new;
  logic [CNT_W-1:0]    cnt_next;
  logic                sample;
  logic                scan_end;
  logic                update;
  logic [4:0]          pop_new;
  logic [KEY_W-1:0]    code_new;

  keypad_scan_sync2 #(.W(NUM_ROWS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row),
    .q     (row_sync)
  );

  assign row_pressed = ~row_sync;
  assign sample      = (div == DIV_LAST);
  assign scan_end    = sample && (col_idx == 2'd3);
  assign idx_next    = col_idx + 2'd1;

  // Snapshot as it will look after this cycle's sample, so end-of-scan logic sees column 3.
  always_comb begin
    snap_new = snap;
    if (sample) snap_new[col_idx*NUM_ROWS +: NUM_ROWS] = row_pressed;
  end

  always_comb begin
    cnt_next = '0;
    if (snap_new == prev_snap) cnt_next = (stable_cnt == CNT_LAST) ? stable_cnt : stable_cnt + 1'b1;
  end

  assign update = scan_end && (cnt_next == CNT_LAST) && (snap_new != deb);

  always_comb begin
    pop_new  = '0;
    code_new = '0;
    for (int i = 0; i < SNAP_W; i++) begin
      pop_new = pop_new + 5'(snap_new[i]);
      if (snap_new[i]) code_new = key_code(2'(i / NUM_ROWS), 2'(i % NUM_ROWS));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div        <= '0;
      col_idx    <= '0;
      col        <= 4'b1110;
      snap       <= '0;
      prev_snap  <= '0;
      stable_cnt <= '0;
      deb        <= '0;
      key        <= '0;
      key_valid  <= 1'b0;
      key_down   <= 1'b0;
      multi      <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (sample) begin
        div     <= '0;
        col_idx <= idx_next;
        col     <= ~(NUM_COLS'(1) << idx_next);
        snap    <= snap_new;
        if (scan_end) begin
          prev_snap  <= snap_new;
          stable_cnt <= cnt_next;
        end
        if (update) begin
          deb <= snap_new;
          if (pop_new == 5'd0) begin
            key_down <= 1'b0;
            multi    <= 1'b0;
          end else if (pop_new == 5'd1) begin
            multi <= 1'b0;
            // Only a press out of an all-released state is a new key; anything else is rollover.
            if (deb == '0) begin
              key       <= code_new;
              key_valid <= 1'b1;
              key_down  <= 1'b1;
            end else begin
              key_down <= (code_new == key);
            end
          end else begin
            multi    <= 1'b1;
            key_down <= 1'b0;
          end
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: directed scenarios plus random key sets checked against a set-level model.
module tb_keypad_scan;
  import keypad_scan_pkg::*;

  localparam int CLK_DIV  = 4;
  localparam int DEBOUNCE = 2;
  localparam int SCAN     = 4 * CLK_DIV;
  localparam int SETTLE   = (DEBOUNCE + 2) * SCAN + 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_down;
  logic       multi;

  logic [15:0] pressed    = '0;
  logic [3:0]  force_low  = '0;
  logic [3:0]  force_high = '0;
  logic [3:0]  pad_rows;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         pulses  = 0;
  logic [3:0] pulse_code = '0;

  always #5 clk = ~clk;

  keypad_scan #(.CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key       (key),
    .key_valid (key_valid),
    .key_down  (key_down),
    .multi     (multi)
  );

  // Ideal keypad matrix: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    pad_rows = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && pressed[c*4+r]) pad_rows[r] = 1'b0;
    row = (pad_rows | force_high) & ~force_low;
  end

  always @(posedge clk) begin
    if (key_valid) begin
      pulses     <= pulses + 1;
      pulse_code <= key;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for the negedge at which col has just switched to target.
  task automatic wait_col_edge(input logic [3:0] target);
    int n = 0;
    while (col === target && n < 2*SCAN) begin @(negedge clk); n++; end
    while (col !== target && n < 4*SCAN) begin @(negedge clk); n++; end
    check_eq("col_reach", col, target);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
  endtask

  // Set-level reference model state.
  logic [15:0] m_deb;
  logic [3:0]  m_key;
  logic        m_kd, m_multi;

  task automatic model_apply(input logic [15:0] s, output int exp_pulse);
    int cnt = 0;
    int code = 0;
    exp_pulse = 0;
    if (s == m_deb) return;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (s[c*4+r]) begin cnt++; code = c*4 + r; end
    if (cnt == 0) begin
      m_kd = 1'b0; m_multi = 1'b0;
    end else if (cnt == 1) begin
      m_multi = 1'b0;
      if (m_deb == '0) begin
        m_key = 4'(code); m_kd = 1'b1; exp_pulse = 1;
      end else begin
        m_kd = (4'(code) == m_key);
      end
    end else begin
      m_multi = 1'b1; m_kd = 1'b0;
    end
    m_deb = s;
  endtask

  initial begin
    int base;
    int last_change;
    int exp_pulse;
    logic [3:0] last_col;
    logic [15:0] s;
    logic first;

    #1 rst_n = 1'b0;
    wait_cycles(2);
    check_eq("rst_col", col, 4'b1110);
    check_eq("rst_key", key, 4'd0);
    check_eq("rst_valid", key_valid, 1'b0);
    check_eq("rst_down", key_down, 1'b0);
    check_eq("rst_multi", multi, 1'b0);
    rst_n = 1'b1;

    // Column rotation and dwell length with idle rows.
    base = pulses; last_col = col; last_change = 0; first = 1'b1;
    for (int i = 1; i <= 3*SCAN; i++) begin
      @(negedge clk);
      if (col !== last_col) begin
        check_eq("col_seq", col, {last_col[2:0], last_col[3]});
        if (!first) check_eq("col_dwell", i - last_change, CLK_DIV);
        first = 1'b0; last_change = i; last_col = col;
      end
    end
    check_eq("idle_pulses", pulses - base, 0);
    check_eq("idle_down", key_down, 1'b0);
    check_eq("idle_multi", multi, 1'b0);

    // One-cycle row glitch away from the sample point.
    base = pulses;
    wait_col_edge(4'b1110);
    force_low = 4'b0001;
    @(negedge clk);
    force_low = '0;
    wait_cycles(4*SCAN);
    check_eq("glitch_pulses", pulses - base, 0);
    check_eq("glitch_down", key_down, 1'b0);
    check_eq("glitch_key", key, 4'd0);

    // Two keys, release one, release all, fresh press.
    base = pulses;
    pressed = 16'h8001;
    wait_cycles(SETTLE);
    check_eq("multi_on", multi, 1'b1);
    check_eq("multi_down", key_down, 1'b0);
    pressed = 16'h0001;
    wait_cycles(SETTLE);
    check_eq("multi_off", multi, 1'b0);
    check_eq("left_down", key_down, 1'b1);
    check_eq("left_key", key, 4'd0);
    check_eq("multi_pulses", pulses - base, 0);
    pressed = '0;
    wait_cycles(SETTLE);
    check_eq("all_up_down", key_down, 1'b0);
    base = pulses;
    pressed = 16'h8000;
    wait_cycles(SETTLE);
    check_eq("k15_pulses", pulses - base, 1);
    check_eq("k15_code", pulse_code, 4'd15);
    check_eq("k15_down", key_down, 1'b1);
    pressed = '0;
    wait_cycles(SETTLE);

    // Clean press of key 9 (col2/row1) and release.
    wait_cycles(7);
    base = pulses;
    pressed = 16'h0200;
    wait_cycles(3*SCAN + 4);
    check_eq("k9_pulses", pulses - base, 1);
    check_eq("k9_code", pulse_code, 4'd9);
    check_eq("k9_down", key_down, 1'b1);
    wait_cycles(2*SCAN);
    check_eq("k9_held", key_down, 1'b1);
    check_eq("k9_one_pulse", pulses - base, 1);
    pressed = '0;
    wait_cycles(SCAN);
    check_eq("k9_rel_early", key_down, 1'b1);
    wait_cycles(2*SCAN + 4);
    check_eq("k9_rel", key_down, 1'b0);
    check_eq("k9_key_hold", key, 4'd9);
    wait_cycles(SCAN);

    // Key 9 with alternating bounce, then stable.
    wait_col_edge(4'b1110);
    base = pulses;
    pressed = 16'h0200;
    for (int i = 0; i < 5; i++) begin
      wait_col_edge(4'b1011);
      if (i % 2 == 1) wait_cycles(2);
      force_high = 4'b0010;
      wait_cycles(3);
      force_high = '0;
    end
    check_eq("bounce_pulses", pulses - base, 0);
    check_eq("bounce_down", key_down, 1'b0);
    wait_cycles(SETTLE);
    check_eq("bounce_accept", pulses - base, 1);
    check_eq("bounce_code", pulse_code, 4'd9);
    pressed = '0;
    wait_cycles(SETTLE);

    // Asynchronous reset mid-scan while key 5 is held.
    pressed = 16'h0020;
    wait_cycles(SETTLE);
    check_eq("k5_down", key_down, 1'b1);
    check_eq("k5_key", key, 4'd5);
    wait_col_edge(4'b1101);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_col", col, 4'b1110);
    check_eq("async_key", key, 4'd0);
    check_eq("async_down", key_down, 1'b0);
    base = pulses;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(SETTLE);
    check_eq("k5_again", pulses - base, 1);
    check_eq("k5_again_code", pulse_code, 4'd5);
    check_eq("k5_again_down", key_down, 1'b1);

    // Random key sets against the set-level model.
    pressed = '0;
    do_reset();
    m_deb = '0; m_key = '0; m_kd = 1'b0; m_multi = 1'b0;
    for (int seg = 0; seg < 30; seg++) begin
      case ($urandom_range(0, 9))
        0, 1, 2:          s = '0;
        3, 4, 5, 6, 7:    s = 16'(1) << $urandom_range(0, 15);
        default:          s = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      endcase
      wait_cycles($urandom_range(0, SCAN-1));
      base = pulses;
      pressed = s;
      model_apply(s, exp_pulse);
      wait_cycles(SETTLE);
      check_eq("rnd_pulses", pulses - base, exp_pulse);
      if (exp_pulse == 1) check_eq("rnd_code", pulse_code, m_key);
      check_eq("rnd_key", key, m_key);
      check_eq("rnd_down", key_down, m_kd);
      check_eq("rnd_multi", multi, m_multi);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
